// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
//  Module   : memory_responder
//  Purpose  : Responder end of the controller memory interface. Serves one
//             word request at a time from on-chip synchronous RAM or from
//             memory-mapped I/O (LEDs, display, switches) with a fixed
//             IDLE -> ACCESS -> RESPOND sequence and a one-cycle response.
//  Revision : 1.0 - initial release
// ============================================================================
module memory_responder #(
  parameter int                     DATA_WIDTH     = 16,
  parameter int                     ADDRESS_WIDTH  = 16,
  parameter int                     RAM_DEPTH_LOG2 = 10,
  parameter logic [ADDRESS_WIDTH-1:0] IO_BASE      = 16'hFF00,
  parameter int                     SWITCH_WIDTH   = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     request_valid,
  input  logic                     request_write,
  input  logic [ADDRESS_WIDTH-1:0] request_address,
  input  logic [DATA_WIDTH-1:0]    request_write_data,
  output logic                     request_ready,
  output logic                     response_valid,
  output logic [DATA_WIDTH-1:0]    response_read_data,
  output logic                     response_error,
  input  logic [SWITCH_WIDTH-1:0]  switches_in,
  output logic [SWITCH_WIDTH-1:0]  leds_out,
  output logic [DATA_WIDTH-1:0]    display_out
);

  localparam int                     RAM_DEPTH  = 1 << RAM_DEPTH_LOG2;
  localparam logic [ADDRESS_WIDTH-1:0] IO_LED     = IO_BASE;
  localparam logic [ADDRESS_WIDTH-1:0] IO_DISPLAY = IO_BASE + ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] IO_SWITCH  = IO_BASE + ADDRESS_WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                   state_q;
  logic                     ready_q;
  logic                     valid_q;
  logic                     error_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     write_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [SWITCH_WIDTH-1:0]  leds_q;
  logic [DATA_WIDTH-1:0]    display_q;
  logic [SWITCH_WIDTH-1:0]  sw_meta_q;
  logic [SWITCH_WIDTH-1:0]  sw_sync_q;

  logic [DATA_WIDTH-1:0]    mem [RAM_DEPTH];

  // Address decode works on the latched request, so it is stable through ACCESS.
  logic is_ram;
  logic is_led;
  logic is_display;
  logic is_switch;
  logic ram_we;

  assign is_ram     = (address_q[ADDRESS_WIDTH-1:RAM_DEPTH_LOG2] == '0);
  assign is_led     = (address_q == IO_LED);
  assign is_display = (address_q == IO_DISPLAY);
  assign is_switch  = (address_q == IO_SWITCH);
  // Gated by reset so a request interrupted in ACCESS never reaches the RAM.
  assign ram_we     = (state_q == ACCESS) && write_q && is_ram && reset;

  // RAM write port: no reset so contents survive a controller reset.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem[address_q[RAM_DEPTH_LOG2-1:0]] <= wdata_q;
    end
  end

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= switches_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Request sequencer: latch, decode/execute, then a single response pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
      leds_q    <= '0;
      display_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (request_valid && ready_q) begin
            write_q   <= request_write;
            address_q <= request_address;
            wdata_q   <= request_write_data;
            ready_q   <= 1'b0;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          state_q <= RESPOND;
          valid_q <= 1'b1;
          error_q <= 1'b0;
          rdata_q <= '0;
          if (is_ram) begin
            if (!write_q) begin
              rdata_q <= mem[address_q[RAM_DEPTH_LOG2-1:0]];
            end
          end else if (is_led) begin
            if (write_q) begin
              leds_q <= wdata_q[SWITCH_WIDTH-1:0];
            end else begin
              rdata_q <= DATA_WIDTH'(leds_q);
            end
          end else if (is_display) begin
            if (write_q) begin
              display_q <= wdata_q;
            end else begin
              rdata_q <= display_q;
            end
          end else if (is_switch && !write_q) begin
            rdata_q <= DATA_WIDTH'(sw_sync_q);
          end else begin
            // Unmapped address or a write to the read-only switch port.
            error_q <= 1'b1;
          end
        end
        RESPOND: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign request_ready      = ready_q;
  assign response_valid     = valid_q;
  assign response_read_data = rdata_q;
  assign response_error     = error_q;
  assign leds_out           = leds_q;
  assign display_out        = display_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_responder
//  Purpose  : Scoreboard bench for memory_responder with a behavioural model
//             of the RAM and I/O map, directed scenarios and random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memory_responder;

  localparam logic [15:0] IOB = 16'hFF00;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        request_valid = 1'b0;
  logic        request_write = 1'b0;
  logic [15:0] request_address = '0;
  logic [15:0] request_write_data = '0;
  logic        request_ready;
  logic        response_valid;
  logic [15:0] response_read_data;
  logic        response_error;
  logic [9:0]  switches_in = '0;
  logic [9:0]  leds_out;
  logic [15:0] display_out;

  memory_responder #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(16), .RAM_DEPTH_LOG2(10),
    .IO_BASE(16'hFF00), .SWITCH_WIDTH(10)
  ) dut (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_write(request_write),
    .request_address(request_address), .request_write_data(request_write_data),
    .request_ready(request_ready), .response_valid(response_valid),
    .response_read_data(response_read_data), .response_error(response_error),
    .switches_in(switches_in), .leds_out(leds_out), .display_out(display_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          accept_edge;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          pulses = 0;

  // Reference model state
  logic [15:0] ref_ram [int];
  logic [9:0]  ref_leds = '0;
  logic [15:0] ref_disp = '0;
  logic [9:0]  ref_sw = '0;
  int          wr_addrs[$];

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
  endtask

  // Memory map rules: RAM below 1024, three I/O words from IOB, all else errors.
  function automatic void model(input logic w, input logic [15:0] a, input logic [15:0] d,
                                output logic [15:0] rd, output logic err);
    rd  = '0;
    err = 1'b0;
    if (int'(a) < 1024) begin
      if (w) ref_ram[int'(a)] = d;
      else if (ref_ram.exists(int'(a))) rd = ref_ram[int'(a)];
    end else if (a == IOB) begin
      if (w) ref_leds = d[9:0];
      else rd = {6'b0, ref_leds};
    end else if (a == IOB + 16'd1) begin
      if (w) ref_disp = d;
      else rd = ref_disp;
    end else if (a == IOB + 16'd2) begin
      if (w) err = 1'b1;
      else rd = {6'b0, ref_sw};
    end else begin
      err = 1'b1;
    end
  endfunction

  // Monitor: every response pulse is matched against the oldest expectation.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (response_valid) begin
        pulses++;
        if (prev) fail_now("pulse_width");
        else if (sb.size() == 0) fail_now("unexpected_response");
        else begin
          e = sb.pop_front();
          check("resp_data", {16'b0, response_read_data}, {16'b0, e.data});
          check("resp_error", {31'b0, response_error}, {31'b0, e.err});
          // The controller captures the pulse at the edge after this sample.
          check("resp_latency", cyc + 1, e.accept_edge + 2);
        end
      end
      prev = response_valid;
    end
  end

  task automatic wait_ready(output logic ok);
    int t;
    t = 0;
    @(negedge clock);
    while (!request_ready && t < 20) begin
      @(negedge clock);
      t++;
    end
    ok = request_ready;
    if (!ok) fail_now("ready_timeout");
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clock);
      t++;
    end
    if (sb.size() != 0) begin
      fail_now("response_timeout");
      sb.delete();
    end
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
    logic ok;
    exp_t e;
    wait_ready(ok);
    if (ok) begin
      model(w, a, d, e.data, e.err);
      e.accept_edge = cyc + 1;
      sb.push_back(e);
      request_valid      = 1'b1;
      request_write      = w;
      request_address    = a;
      request_write_data = d;
      @(negedge clock);
      request_valid = 1'b0;
      request_write = 1'b0;
      drain();
      check("leds_out", {22'b0, leds_out}, {22'b0, ref_leds});
      check("display_out", {16'b0, display_out}, {16'b0, ref_disp});
    end
  endtask

  task automatic set_switches(input logic [9:0] v);
    @(negedge clock);
    switches_in = v;
    repeat (3) @(negedge clock);
    ref_sw = v;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic        ok;
    int          acc;
    int          p0;
    int          k;
    logic [15:0] a;
    logic        w;
    exp_t        e;

    // Reset and reset-state checks
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", {31'b0, request_ready}, 32'd1);
    check("rst_valid", {31'b0, response_valid}, 32'd0);
    check("rst_data", {16'b0, response_read_data}, 32'd0);
    check("rst_error", {31'b0, response_error}, 32'd0);
    check("rst_leds", {22'b0, leds_out}, 32'd0);
    check("rst_display", {16'b0, display_out}, 32'd0);
    reset = 1'b1;

    // RAM write/read
    issue(1'b1, 16'd5, 16'hBEEF);
    issue(1'b0, 16'd5, 16'h0000);

    // Display and LEDs
    issue(1'b1, IOB + 16'd1, 16'h1234);
    issue(1'b0, IOB + 16'd1, 16'h0000);
    issue(1'b1, IOB, 16'hFFFF);
    issue(1'b0, IOB, 16'h0000);

    // Switches and read-only protection
    set_switches(10'h2A5);
    issue(1'b0, IOB + 16'd2, 16'h0000);
    issue(1'b1, IOB + 16'd2, 16'h5555);
    issue(1'b0, IOB + 16'd2, 16'h0000);

    // Address boundaries
    issue(1'b0, 16'd1024, 16'h0000);
    issue(1'b0, IOB + 16'd3, 16'h0000);
    issue(1'b0, IOB - 16'd1, 16'h0000);
    issue(1'b1, 16'd1023, 16'h0007);
    issue(1'b0, 16'd1023, 16'h0000);
    issue(1'b1, 16'd0, 16'hA5A5);
    issue(1'b0, 16'd0, 16'h0000);
    wr_addrs.push_back(5);
    wr_addrs.push_back(1023);
    wr_addrs.push_back(0);

    // Held request: 6 edges of request_valid give two accepts
    wait_ready(ok);
    p0  = pulses;
    acc = 0;
    request_valid   = 1'b1;
    request_write   = 1'b0;
    request_address = 16'd5;
    for (int i = 0; i < 6; i++) begin
      if (request_ready) begin
        model(1'b0, 16'd5, 16'h0000, e.data, e.err);
        e.accept_edge = cyc + 1;
        sb.push_back(e);
        acc++;
      end
      @(negedge clock);
    end
    request_valid = 1'b0;
    drain();
    repeat (4) @(negedge clock);
    check("held_accepts", acc, 2);
    check("held_pulses", pulses - p0, 2);

    // Reset during ACCESS of a write to addr 9: no response, write dropped
    issue(1'b1, 16'd9, 16'h0909);
    wr_addrs.push_back(9);
    wait_ready(ok);
    request_valid      = 1'b1;
    request_write      = 1'b1;
    request_address    = 16'd9;
    request_write_data = 16'hDEAD;
    @(negedge clock);
    request_valid = 1'b0;
    request_write = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    ref_leds = '0;
    ref_disp = '0;
    repeat (4) @(negedge clock);
    check("midrst_ready", {31'b0, request_ready}, 32'd1);
    check("midrst_leds", {22'b0, leds_out}, 32'd0);
    issue(1'b0, 16'd9, 16'h0000);
    issue(1'b0, IOB + 16'd2, 16'h0000);

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      w = 1'($urandom_range(0, 1));
      case (k)
        0, 1, 2: begin
          a = 16'($urandom_range(0, 1023));
          wr_addrs.push_back(int'(a));
          issue(1'b1, a, 16'($urandom));
        end
        3, 4: begin
          a = 16'(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]);
          issue(1'b0, a, 16'h0000);
        end
        5: issue(w, IOB, 16'($urandom));
        6: issue(w, IOB + 16'd1, 16'($urandom));
        7: begin
          set_switches(10'($urandom));
          issue(w, IOB + 16'd2, 16'($urandom));
        end
        8: begin
          if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(1024, 16'hFEFF));
          else a = 16'($urandom_range(16'hFF03, 16'hFFFF));
          issue(w, a, 16'($urandom));
        end
        default: issue(1'b0, IOB + 16'd2, 16'h0000);
      endcase
    end

    repeat (5) @(negedge clock);
    if (sb.size() != 0) fail_now("leftover_expectations");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
